// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_write_arbiter_pkg : shared types/constants for the arbiter |
// | rev 1.0                                                            |
// +------------------------------------------------------------------+
package regfile_write_arbiter_pkg;

  localparam int DEFAULT_BITSIZE = 32;
  localparam int DEFAULT_REGSIZE = 32;

  // Bit positions of each requester in request/grant vectors
  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter2 : two-way round-robin arbiter, pointer moves on grant  |
// | rev 1.0                                                            |
// +------------------------------------------------------------------+
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // High when B should win the next tie (i.e. A was granted last)
  logic prio_b_q, prio_b_d;

  always_comb begin
    gnt      = 2'b00;
    prio_b_d = prio_b_q;
    if (en) begin
      if (req[REQ_A] && (!req[REQ_B] || !prio_b_q)) begin
        gnt[REQ_A] = 1'b1;
      end else if (req[REQ_B]) begin
        gnt[REQ_B] = 1'b1;
      end
    end
    if (gnt[REQ_A]) begin
      prio_b_d = 1'b1;
    end else if (gnt[REQ_B]) begin
      prio_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b_q <= 1'b0;
    end else begin
      prio_b_q <= prio_b_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_write_arbiter : arbitrates ALU/load writebacks, clear seq  |
// | rev 1.0                                                            |
// +------------------------------------------------------------------+
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int BITSIZE = DEFAULT_BITSIZE,
  parameter int REGSIZE = DEFAULT_REGSIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  input  logic [$clog2(REGSIZE)-1:0] a_sel,
  input  logic [BITSIZE-1:0]         a_data,
  output logic                       a_ready,
  input  logic                       b_valid,
  input  logic [$clog2(REGSIZE)-1:0] b_sel,
  input  logic [BITSIZE-1:0]         b_data,
  output logic                       b_ready,
  input  logic                       clear_req,
  output logic                       busy,
  output logic                       WriteEnable,
  output logic [$clog2(REGSIZE)-1:0] WriteSelect,
  output logic [BITSIZE-1:0]         WriteData
);

  localparam int SEL_W = $clog2(REGSIZE);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(REGSIZE - 1);
  localparam logic [SEL_W-1:0] FIRST_IDX = SEL_W'(1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               we_q, we_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [BITSIZE-1:0] data_q, data_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       arb_en;

  assign req[REQ_A] = a_valid;
  assign req[REQ_B] = b_valid;
  assign arb_en     = (state_q == ST_RUN) && !rst;

  rr_arbiter2 u_rr_arbiter2 (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (req),
    .gnt (gnt)
  );

  assign a_ready     = gnt[REQ_A];
  assign b_ready     = gnt[REQ_B];
  assign busy        = (state_q == ST_CLEAR);
  assign WriteEnable = we_q;
  assign WriteSelect = sel_q;
  assign WriteData   = data_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    sel_d   = sel_q;
    data_d  = data_q;
    case (state_q)
      ST_RUN: begin
        // Register 0 is hardwired: accept the transfer but suppress the strobe
        if (gnt[REQ_A]) begin
          we_d   = (a_sel != '0);
          sel_d  = a_sel;
          data_d = a_data;
        end else if (gnt[REQ_B]) begin
          we_d   = (b_sel != '0);
          sel_d  = b_sel;
          data_d = b_data;
        end
        if (clear_req) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        we_d   = 1'b1;
        sel_d  = idx_q;
        data_d = '0;
        if (idx_q == LAST_IDX) begin
          idx_d   = FIRST_IDX;
          state_d = ST_RUN;
        end else begin
          idx_d = idx_q + FIRST_IDX;
        end
      end
      default: begin
        state_d = ST_RUN;
        idx_d   = FIRST_IDX;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      idx_q   <= FIRST_IDX;
      we_q    <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_regfile_write_arbiter : directed stimulus with write scoreboard |
// | rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_regfile_write_arbiter;

  localparam int BITSIZE = 32;
  localparam int REGSIZE = 32;
  localparam int SEL_W   = $clog2(REGSIZE);

  logic               clk = 1'b0;
  logic               rst;
  logic               a_valid, b_valid, clear_req;
  logic [SEL_W-1:0]   a_sel, b_sel;
  logic [BITSIZE-1:0] a_data, b_data;
  logic               a_ready, b_ready, busy;
  logic               WriteEnable;
  logic [SEL_W-1:0]   WriteSelect;
  logic [BITSIZE-1:0] WriteData;

  regfile_write_arbiter #(.BITSIZE(BITSIZE), .REGSIZE(REGSIZE)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_sel       (a_sel),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_sel       (b_sel),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .clear_req   (clear_req),
    .busy        (busy),
    .WriteEnable (WriteEnable),
    .WriteSelect (WriteSelect),
    .WriteData   (WriteData)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SEL_W-1:0]   sel;
    logic [BITSIZE-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [SEL_W-1:0] sel, input logic [BITSIZE-1:0] data);
    wr_t w;
    w.sel  = sel;
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic push_clear(input int last);
    for (int i = 1; i <= last; i++) push_wr(SEL_W'(i), '0);
  endtask

  // Monitor: every observed write strobe must match the next expected write
  always @(negedge clk) begin
    if (WriteEnable === 1'b1) begin
      wr_t w;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got sel=%0d data=%0h expected no write",
                 WriteSelect, WriteData);
      end else begin
        w = exp_q.pop_front();
        if (WriteSelect !== w.sel || WriteData !== w.data) begin
          fails++;
          $display("FAIL write_seq: got sel=%0d data=%0h expected sel=%0d data=%0h",
                   WriteSelect, WriteData, w.sel, w.data);
        end
      end
    end
  end

  // Waits through a clear sequence, checking that A is held off; returns busy cycle count
  task automatic run_clear(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      check("ready_in_clear", {62'd0, a_ready, b_ready}, 64'd0);
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cnt;
    logic [1:0] exp_gnt [4];
    rst = 1'b1; clear_req = 1'b0;
    a_valid = 1'b1; a_sel = 5'd4; a_data = 32'h1;
    b_valid = 1'b1; b_sel = 5'd6; b_data = 32'h2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {62'd0, a_ready, b_ready}, 64'd0);
    check("rst_outputs", {30'd0, busy, WriteEnable, WriteSelect, WriteData}, 64'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b0;

    // Round-robin from reset: A,B,A,B
    exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
    a_valid = 1'b1; a_sel = 5'd1; a_data = 32'h11;
    b_valid = 1'b1; b_sel = 5'd2; b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_grant", {62'd0, a_ready, b_ready}, {62'd0, exp_gnt[i]});
      if (exp_gnt[i][1]) push_wr(5'd1, 32'h11);
      else               push_wr(5'd2, 32'h22);
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);

    // Single A request, latency 1
    a_valid = 1'b1; a_sel = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    check("a_only_ready", {62'd0, a_ready, b_ready}, 64'b10);
    push_wr(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    a_valid = 1'b0;
    check("a_only_we", {63'd0, WriteEnable}, 64'd1);
    @(negedge clk);
    check("idle_hold", {31'd0, WriteEnable, WriteSelect, WriteData}, {32'd5, 32'hDEADBEEF});

    // sel=0 accepted but no strobe
    b_valid = 1'b1; b_sel = 5'd0; b_data = 32'hFFFF;
    #1;
    check("sel0_ready", {62'd0, a_ready, b_ready}, 64'b01);
    @(negedge clk);
    b_valid = 1'b0;
    check("sel0_no_we", {63'd0, WriteEnable}, 64'd0);

    // Pointer moved on the sel=0 grant, so A wins the tie
    a_valid = 1'b1; a_sel = 5'd8; a_data = 32'h88;
    b_valid = 1'b1; b_sel = 5'd9; b_data = 32'h99;
    #1;
    check("tie_after_sel0", {62'd0, a_ready, b_ready}, 64'b10);
    push_wr(5'd8, 32'h88);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check("b_after_tie", {62'd0, a_ready, b_ready}, 64'b01);
    push_wr(5'd9, 32'h99);
    @(negedge clk);
    b_valid = 1'b0;

    // Grant coincident with clear_req: write first, then clear 1..31
    a_valid = 1'b1; a_sel = 5'd7; a_data = 32'h77; clear_req = 1'b1;
    #1;
    check("grant_with_clear", {62'd0, a_ready, b_ready}, 64'b10);
    push_wr(5'd7, 32'h77);
    push_clear(REGSIZE - 1);
    @(negedge clk);
    clear_req = 1'b0;
    a_sel = 5'd3; a_data = 32'h33;
    check("busy_start", {63'd0, busy}, 64'd1);
    run_clear(cnt);
    check("clear_len", 64'(cnt), 64'd31);
    check("resume_grant", {62'd0, a_ready, b_ready}, 64'b10);
    push_wr(5'd3, 32'h33);
    @(negedge clk);

    // Same register from both requesters: order follows grants (B wins after A)
    a_sel = 5'd9; a_data = 32'hA9;
    b_valid = 1'b1; b_sel = 5'd9; b_data = 32'hB9;
    #1;
    check("same_sel_b_first", {62'd0, a_ready, b_ready}, 64'b01);
    push_wr(5'd9, 32'hB9);
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    check("same_sel_a_second", {62'd0, a_ready, b_ready}, 64'b10);
    push_wr(5'd9, 32'hA9);
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);

    // Reset while clear index is 10: writes 1..9 seen, then abort
    clear_req = 1'b1;
    push_clear(9);
    @(negedge clk);
    clear_req = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort", {30'd0, busy, WriteEnable, WriteSelect, WriteData}, 64'd0);
    rst = 1'b0;
    check("queue_after_abort", 64'(exp_q.size()), 64'd0);

    // Clear restarts from index 1
    clear_req = 1'b1;
    push_clear(REGSIZE - 1);
    @(negedge clk);
    clear_req = 1'b0;
    run_clear(cnt);
    check("clear_len2", 64'(cnt), 64'd31);
    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
